// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter/sequencer for the block data memory.
// Optional watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int BLOCK_W        = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rq0_valid,
  input  logic               i_rq0_we,
  input  logic [ADDR_W-1:0]  i_rq0_addr,
  input  logic [BLOCK_W-1:0] i_rq0_wdata,
  input  logic               i_rq1_valid,
  input  logic               i_rq1_we,
  input  logic [ADDR_W-1:0]  i_rq1_addr,
  input  logic [BLOCK_W-1:0] i_rq1_wdata,
  output logic               o_rq0_ack,
  output logic               o_rq1_ack,
  output logic [BLOCK_W-1:0] o_rq0_rdata,
  output logic [BLOCK_W-1:0] o_rq1_rdata,
  output logic               o_rq_err,
  output logic               o_mem_ren,
  output logic               o_mem_wen,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [BLOCK_W-1:0] o_mem_din,
  input  logic               i_mem_ready,
  input  logic               i_mem_done,
  input  logic [BLOCK_W-1:0] i_mem_dout
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, GAP} state_t;
  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  state_t r_state, w_state;
  logic r_last, w_last;
  logic r_ren, w_ren, r_wen, w_wen;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [BLOCK_W-1:0] r_din, w_din, r_rdata0, w_rdata0, r_rdata1, w_rdata1, w_rd;
  logic r_ack0, w_ack0, r_ack1, w_ack1, r_err, w_err;
  logic w_pick, w_we, w_fin, w_tmo;
  // r_last doubles as the current winner once a grant has been made
  assign w_pick = (i_rq0_valid && i_rq1_valid) ? ~r_last : i_rq1_valid;
  assign w_we   = w_pick ? i_rq1_we : i_rq0_we;
  assign w_fin  = (r_state == READ && i_mem_ready) || (r_state == WRITE && i_mem_done);
  assign w_rd   = w_fin ? i_mem_dout : '0;
`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cnt <= '0;
    else r_cnt <= (r_state == IDLE) ? '0 : (r_state == READ || r_state == WRITE) ? r_cnt + 1'b1 : r_cnt;
  end
  assign w_tmo = (r_state == READ || r_state == WRITE) && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_state  = r_state;
    w_last   = r_last;
    w_ren    = r_ren;
    w_wen    = r_wen;
    w_addr   = r_addr;
    w_din    = r_din;
    w_rdata0 = r_rdata0;
    w_rdata1 = r_rdata1;
    w_ack0   = 1'b0;
    w_ack1   = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE: if (i_rq0_valid || i_rq1_valid) begin
        w_last  = w_pick;
        w_ren   = ~w_we;
        w_wen   = w_we;
        w_addr  = w_pick ? i_rq1_addr : i_rq0_addr;
        w_din   = w_pick ? i_rq1_wdata : i_rq0_wdata;
        w_state = w_we ? WRITE : READ;
      end
      READ, WRITE: if (w_fin || w_tmo) begin
        w_state = GAP;
        w_ren   = 1'b0;
        w_wen   = 1'b0;
        w_ack0  = ~r_last;
        w_ack1  = r_last;
        w_err   = ~w_fin;
        if (r_state == READ) begin
          w_rdata0 = r_last ? r_rdata0 : w_rd;
          w_rdata1 = r_last ? w_rd : r_rdata1;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_ren    <= w_ren;
      r_wen    <= w_wen;
      r_addr   <= w_addr;
      r_din    <= w_din;
      r_rdata0 <= w_rdata0;
      r_rdata1 <= w_rdata1;
      r_ack0   <= w_ack0;
      r_ack1   <= w_ack1;
      r_err    <= w_err;
    end
  end
  assign o_rq0_ack   = r_ack0;
  assign o_rq1_ack   = r_ack1;
  assign o_rq0_rdata = r_rdata0;
  assign o_rq1_rdata = r_rdata1;
  assign o_rq_err    = r_err;
  assign o_mem_ren   = r_ren;
  assign o_mem_wen   = r_wen;
  assign o_mem_addr  = r_addr;
  assign o_mem_din   = r_din;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and sequencer in front of the block-granular data memory. It serialises block read/write requests from two requesters, such as the D-cache miss/write-back engine and a secondary master. It drives the memory's level-held ren/wen handshake and inserts the mandatory idle gap between transactions. It returns one-cycle completion pulses with registered read data to the winning requester.

## Interface
- ADDR_W, 10: block address width (matches memory block-address width)
- BLOCK_W, 128: block data width in bits
- TIMEOUT_CYCLES, 64: watchdog limit in cycles (used only with DMEM_ARB_TIMEOUT_EN)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- rq0_valid / rq1_valid  in  1  request pending; held with fields stable until matching ack
- rq0_we / rq1_we  in  1  1 = block write, 0 = block read
- rq0_addr / rq1_addr  in  ADDR_W  block address
- rq0_wdata / rq1_wdata  in  BLOCK_W  write block data
- rq0_ack / rq1_ack  out  1  one-cycle completion pulse
- rq0_rdata / rq1_rdata  out  BLOCK_W  read block; valid with ack, held until that port's next ack
- rq_err  out  1  one-cycle pulse with ack when the transaction timed out
- mem_ren, mem_wen  out  1  memory handshake, registered, never both high
- mem_addr  out  ADDR_W  registered block address
- mem_din  out  BLOCK_W  registered write data
- mem_ready, mem_done  in  1  memory read-ready / write-done (registered at memory)
- mem_dout  in  BLOCK_W  memory read data, valid only while mem_ready and mem_ren are high

## Operation
- States: IDLE, READ, WRITE, GAP.
- IDLE: if any rqN_valid, select a winner and latch its we/addr/wdata into mem_* registers. Go to READ (mem_ren=1) or WRITE (mem_wen=1).
- Arbitration: round-robin. A `last` bit records the last granted port. When both ports are valid, the port other than `last` wins. A single valid port always wins. `last` updates on grant.
- READ: hold mem_ren, mem_addr. On mem_ready=1, capture mem_dout into the winner's rdata at that edge. Go to GAP.
- WRITE: hold mem_wen, mem_addr, mem_din. On mem_done=1, go to GAP.
- GAP: mem_ren=mem_wen=0 for exactly one cycle. Winner's ack=1 during this cycle. The next state is always IDLE, and requests are not sampled in GAP. The gap guarantees that the memory's delay counter and write-data latch rearm.
- mem_ren and mem_wen must never be high in the same cycle. mem_addr/mem_din must not change while either is high.
- Requester valid dropped mid-transaction: ignored; the transaction completes and ack still pulses.

## Timing
- Reset values: state IDLE; mem_ren=mem_wen=0; mem_addr=0; mem_din=0; rq0_ack=rq1_ack=0; rq_err=0; rq0_rdata=rq1_rdata=0; last=1 (port 0 wins the first tie).
- Grant edge E0 (IDLE, valid high): mem_ren/wen high from E0.
- Completion edge En (mem_ready/mem_done sampled high): ack high from En to En+1; state IDLE after En+1. Earliest next grant is at En+2.
- Requester may update valid/fields at En+1 (on seeing ack). The arbiter must not reissue a completed request.
- For memory latency L cycles (ren high to ready high), a transaction costs L+3 cycles, grant to next possible grant.
- Reset asserted mid-transaction: all outputs return to reset values immediately. The pending transaction is lost without ack.

## Configuration
- DMEM_ARB_TIMEOUT_EN defined: a counter, cleared on grant, increments each cycle in READ/WRITE. When it reaches TIMEOUT_CYCLES without completion, go to GAP. The winner's ack and rq_err pulse together; for reads, rdata is set to 0.
- Not defined: no counter; READ/WRITE wait indefinitely; rq_err tied to 0.

## Test plan
- Single read, port 0, addr 0x005, memory latency 7 -> mem_ren high 8 cycles; rq0_ack one cycle; rq0_rdata equals preloaded block 0x005; rq1_ack stays 0.
- Write then read, port 1: write 0xA5A5… to addr 0x010, then read 0x010 -> mem_wen and mem_ren separated by ≥1 low cycle; rdata = 0xA5A5….
- Both ports valid continuously, 4 reads each -> grants alternate 0,1,0,1…; each port gets exactly 4 acks; no cycle with mem_ren&mem_wen.
- Back-to-back writes from port 0 to 0x001 (data X) and 0x002 (data Y) -> both blocks written with correct distinct data; GAP cycle observed between them.
- Reset asserted 3 cycles into a read -> mem_ren=0, acks 0, rdata 0 in same cycle; after release, a new request completes normally.
- With DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, memory stubbed never ready -> after 16 cycles in READ, rq0_ack and rq_err pulse together, rq0_rdata=0, arbiter returns to IDLE.
